// File: rtl/fir_ram_mac_seq_if.sv
// Bus bundle for fir_ram_mac_seq: sample stream, coefficient write port,
// accumulator link and filter result.
interface fir_ram_mac_seq_if #(
  parameter int DWIDTH  = 16,
  parameter int CWIDTH  = 16,
  parameter int TAPS    = 16,
  parameter int AWIDTH  = $clog2(TAPS),
  parameter int PWIDTH  = DWIDTH + CWIDTH,
  parameter int ACWIDTH = PWIDTH + AWIDTH
);
  logic [DWIDTH-1:0]  x_i;
  logic               x_valid_i;
  logic               x_ready_o;
  logic               coef_we_i;
  logic [AWIDTH-1:0]  coef_addr_i;
  logic [CWIDTH-1:0]  coef_i;
  logic               acc_clr_o;
  logic               acc_ena_o;
  logic [PWIDTH-1:0]  prod_o;
  logic [ACWIDTH-1:0] acc_i;
  logic [ACWIDTH-1:0] y_o;
  logic               y_valid_o;
  logic               busy_o;

  modport slave (
    input  x_i, x_valid_i, coef_we_i, coef_addr_i, coef_i, acc_i,
    output x_ready_o, acc_clr_o, acc_ena_o, prod_o, y_o, y_valid_o, busy_o
  );

  modport master (
    output x_i, x_valid_i, coef_we_i, coef_addr_i, coef_i, acc_i,
    input  x_ready_o, acc_clr_o, acc_ena_o, prod_o, y_o, y_valid_o, busy_o
  );
endinterface

// File: rtl/fir_ram_mac_seq.sv
// Time-multiplexed multiply sequencer for the RAM-based FIR: buffers samples,
// walks all taps feeding an external accumulator, then captures the result.
//
// state   | meaning
// S_INIT  | zero the sample buffer, one location per cycle
// S_IDLE  | ready for a sample; coefficient writes allowed
// S_RUN   | issue one tap address per cycle
// S_FLUSH | drain read and multiply stages
// S_DONE  | accumulator final, capture into y_o
module fir_ram_mac_seq #(
  parameter int DWIDTH  = 16,
  parameter int CWIDTH  = 16,
  parameter int TAPS    = 16,
  parameter int AWIDTH  = $clog2(TAPS),
  parameter int PWIDTH  = DWIDTH + CWIDTH,
  parameter int ACWIDTH = PWIDTH + AWIDTH
) (
  input logic              clk_i,
  input logic              rst_i,
  fir_ram_mac_seq_if.slave bus
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  localparam logic [AWIDTH-1:0] LAST_TAP = AWIDTH'(TAPS - 1);

  state_t                    r_state;
  logic [AWIDTH-1:0]         r_cnt;
  logic [AWIDTH-1:0]         r_wr_ptr;
  logic [AWIDTH-1:0]         r_base;
  logic                      r_x_ready;
  logic                      r_busy;
  logic                      r_v1;
  logic                      r_acc_ena;
  logic                      r_y_valid;
  logic signed [PWIDTH-1:0]  r_prod;
  logic [ACWIDTH-1:0]        r_y;

  logic [DWIDTH-1:0]         r_sbuf [TAPS];
  logic [CWIDTH-1:0]         r_cbuf [TAPS];
  logic signed [DWIDTH-1:0]  r_x_rd;
  logic signed [CWIDTH-1:0]  r_h_rd;

  logic                      w_accept;
  logic                      w_sb_we;
  logic [AWIDTH-1:0]         w_sb_waddr;
  logic [AWIDTH-1:0]         w_sb_raddr;
  logic [DWIDTH-1:0]         w_sb_wdata;
  logic signed [PWIDTH-1:0]  w_prod;

  assign w_accept   = bus.x_valid_i & r_x_ready;
  assign w_sb_we    = (r_state == S_INIT) | w_accept;
  assign w_sb_waddr = (r_state == S_INIT) ? r_cnt : r_wr_ptr;
  assign w_sb_wdata = (r_state == S_INIT) ? '0 : bus.x_i;
  // Tap k reads the sample k steps older than the newest; wraps mod TAPS.
  assign w_sb_raddr = r_base - r_cnt;
  assign w_prod     = r_x_rd * r_h_rd;

  // Buffers are not reset: samples are zeroed by S_INIT, coefficients by software.
  always_ff @(posedge clk_i) begin
    if (w_sb_we) r_sbuf[w_sb_waddr] <= w_sb_wdata;
    if (bus.coef_we_i && !r_busy) r_cbuf[bus.coef_addr_i] <= bus.coef_i;
    r_x_rd <= r_sbuf[w_sb_raddr];
    r_h_rd <= r_cbuf[r_cnt];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_INIT;
      r_cnt     <= '0;
      r_wr_ptr  <= '0;
      r_base    <= '0;
      r_x_ready <= 1'b0;
      r_busy    <= 1'b1;
      r_v1      <= 1'b0;
      r_acc_ena <= 1'b0;
      r_prod    <= '0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else begin
      r_y_valid <= 1'b0;
      r_v1      <= (r_state == S_RUN);
      r_acc_ena <= r_v1;
      r_prod    <= r_v1 ? w_prod : '0;
      case (r_state)
        S_INIT: begin
          r_cnt <= r_cnt + AWIDTH'(1);
          if (r_cnt == LAST_TAP) begin
            r_state   <= S_IDLE;
            r_x_ready <= 1'b1;
            r_busy    <= 1'b0;
          end
        end
        S_IDLE: begin
          if (w_accept) begin
            r_base    <= r_wr_ptr;
            r_wr_ptr  <= r_wr_ptr + AWIDTH'(1);
            r_cnt     <= '0;
            r_state   <= S_RUN;
            r_x_ready <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + AWIDTH'(1);
          if (r_cnt == LAST_TAP) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          r_cnt <= r_cnt + AWIDTH'(1);
          if (r_cnt == AWIDTH'(1)) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_y       <= bus.acc_i;
          r_y_valid <= 1'b1;
          r_state   <= S_IDLE;
          r_x_ready <= 1'b1;
          r_busy    <= 1'b0;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign bus.x_ready_o = r_x_ready;
  assign bus.acc_clr_o = w_accept;
  assign bus.acc_ena_o = r_acc_ena;
  assign bus.prod_o    = r_prod;
  assign bus.y_o       = r_y;
  assign bus.y_valid_o = r_y_valid;
  assign bus.busy_o    = r_busy;

endmodule

// File: doc/fir_ram_mac_seq.md
# fir_ram_mac_seq

Time-multiplexed multiply sequencer for the RAM-based FIR. It accepts one input sample at a time and stores it in an internal circular sample buffer. It then walks all taps, reads sample/coefficient pairs, multiplies them and drives the downstream accumulator (`clr`, `clk_ena`, `data`) one product per cycle. When the walk is done it captures the accumulator result as the filter output.

## Interface
Parameters:
- DWIDTH, 16, sample width, signed
- CWIDTH, 16, coefficient width, signed
- TAPS, 16, number of taps, ≥ 2, power of two
- AWIDTH, $clog2(TAPS), tap address width
- PWIDTH, DWIDTH+CWIDTH, product width
- ACWIDTH, PWIDTH+AWIDTH, accumulator/output width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- x_i  in  DWIDTH  input sample, signed
- x_valid_i  in  1  sample valid
- x_ready_o  out  1  sample accepted when `x_valid_i & x_ready_o` at a rising edge
- coef_we_i  in  1  coefficient write strobe
- coef_addr_i  in  AWIDTH  coefficient tap index
- coef_i  in  CWIDTH  coefficient value, signed
- acc_clr_o  out  1  to accumulator `clr_i`
- acc_ena_o  out  1  to accumulator `clk_ena_i`
- prod_o  out  PWIDTH  to accumulator `data_i`, signed
- acc_i  in  ACWIDTH  from accumulator `accum_o`
- y_o  out  ACWIDTH  filter output, signed
- y_valid_o  out  1  one-cycle pulse, `y_o` valid
- busy_o  out  1  high in every state except IDLE

## Operation
- States are INIT → IDLE → RUN → FLUSH → DONE → IDLE.
- **INIT (after reset):**
  - Writes zero to sample buffer locations 0..TAPS-1, one per cycle, taking TAPS cycles.
  - `x_ready_o` = 0; then go to IDLE.
- **IDLE:**
  - `x_ready_o` = 1.
  - On accept: write `x_i` at `wr_ptr`, latch `base` = `wr_ptr`, increment `wr_ptr` mod TAPS, go to RUN.
- **acc_clr_o** = `x_valid_i & x_ready_o`, combinational. The accumulator is cleared on the accept edge.
- **RUN:** TAPS cycles. Tap k = 0..TAPS-1 issues sample address (`base` − k) mod TAPS and coefficient address k. Tap 0 is the newest sample.
- **Read pipeline:**
  - RAM read: 1 registered stage.
  - Product `x*h`: full-precision signed, 1 registered stage into `prod_o`.
  - `acc_ena_o` is high exactly while `prod_o` holds a valid product, TAPS cycles in total.
- **FLUSH:** 2 cycles to drain the pipeline.
- **DONE:** 1 cycle. The accumulator is final; register `y_o` ← `acc_i` and pulse `y_valid_o`; go to IDLE.
- **Result:** y = Σ_{k} h[k]·x[n−k]. ACWIDTH guarantees no overflow; no rounding and no saturation.
- **Coefficient RAM:**
  - Written via `coef_we_i`/`coef_addr_i`/`coef_i` only while `busy_o` = 0.
  - Writes while busy are ignored.
  - Not cleared by reset; software loads it.
- **Sample buffer:** contents are only defined via INIT and accepts.
- **Outputs when idle:** `prod_o` = 0 whenever `acc_ena_o` = 0.

## Timing
Cycle 0 is the cycle containing the accept edge.
- **Reset values:**
  - `x_ready_o` = 0, `acc_clr_o` = 0 (since `x_ready_o` = 0)
  - `acc_ena_o` = 0, `prod_o` = 0
  - `y_o` = 0, `y_valid_o` = 0
  - `busy_o` = 1
  - State INIT, `wr_ptr` = 0
- **Per-sample schedule:**
  - Tap k address is issued in cycle 1+k.
  - RAM data is available in cycle 2+k.
  - `prod_o`/`acc_ena_o` are valid in cycle 3+k.
  - `acc_ena_o` is high in cycles 3..TAPS+2.
- **Output:** DONE is cycle TAPS+3. `y_valid_o` and the new `y_o` appear in cycle TAPS+4, where `x_ready_o` = 1 again (IDLE).
- **Throughput:** one sample per TAPS+4 cycles. With `x_valid_i` held high, the next accept happens in cycle TAPS+4, the same cycle as the `y_valid_o` pulse.
- **Output hold:** `y_o` holds its value until the next DONE.
- **Read-after-write:** a sample written at edge 0 is read by tap 0 in cycle 1 and returns the new value.
- **`wr_ptr` wrap:** wraps TAPS-1 → 0; sample address arithmetic is modulo TAPS.
- **Reset mid-operation:**
  - Abort immediately; all outputs return to reset values.
  - No `y_valid_o` for the aborted sample.
  - INIT reruns and the buffer is re-zeroed.
- **Coefficient write in the same cycle as an accept:** allowed (state is IDLE); the write takes effect for that sample.

## Test plan
- **Reset/INIT:**
  - Drive `rst_i` high then low → `x_ready_o` = 0 for exactly TAPS cycles (16), then 1.
  - `busy_o` falls in the same cycle.
  - All outputs are 0 throughout.
- **Impulse (TAPS = 16):**
  - Load h[k] = k+1, feed 1 then 20 zeros → `y_o` = 1, 2, …, 16, then 0, 0, ….
  - Each `y_valid_o` comes exactly 20 cycles after its accept edge.
- **Full-scale:**
  - Load h[k] = −32768, feed 16 samples of −32768 → the 16th output is 2^34 (= 17179869184), with no wrap.
- **Back-to-back:**
  - Hold `x_valid_i` = 1 with a ramp 1, 2, 3, … → accepts spaced 20 cycles apart.
  - `acc_ena_o` is high 16 cycles per sample.
  - `acc_clr_o` pulses coincide with the accepts.
- **Coefficient write while busy:**
  - During RUN, write h[0] = 1000 → ignored; the output matches the old coefficients.
  - The same write in IDLE takes effect on the next sample.
- **Reset mid-RUN:**
  - Assert `rst_i` at tap 7 → no `y_valid_o` for that sample; INIT reruns.
  - After a following impulse, outputs match the clean impulse response (old samples are gone).
